// File: rtl/result_drain.sv
// result_drain: double-buffered result frame drain.
// Captures whole result frames (words x (dw+1) bits plus a base word address)
// into two ping-pong buffers and streams them out one word per handshake,
// with the address of each word being base_addr + k.
//
// Ports:
//   clk, n_reset             clock, asynchronous active-low reset
//   load_valid/load_ready    frame offer / buffer-free (registered)
//   load_data, base_addr     frame payload and destination address of word 0
//   out_valid/out_ready      output word handshake
//   out_data, out_addr       current word and its destination address
//   out_last                 current word is the final word of its frame
//   busy                     at least one buffer occupied
//   frame_count              completed frames, modulo 256
module result_drain #(
    parameter int unsigned dw    = 31,
    parameter int unsigned aw    = 31,
    parameter int unsigned words = 8
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [words*(dw+1)-1:0]  load_data,
    input  logic [aw:0]              base_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [dw:0]              out_data,
    output logic [aw:0]              out_addr,
    output logic                     out_last,
    output logic                     busy,
    output logic [7:0]               frame_count
);

    localparam int unsigned W  = dw + 1;
    localparam int unsigned AW = aw + 1;
    localparam int unsigned FW = words * W;
    localparam int unsigned KW = (words > 1) ? $clog2(words) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(words - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [FW-1:0] buf_data [2];
    logic [aw:0]   buf_addr [2];

    logic [1:0]    full, full_nxt;
    logic          wr_ptr, wr_nxt;
    logic          rd_ptr, rd_nxt;
    logic [KW-1:0] k, k_nxt;
    logic [7:0]    fc_nxt;

    logic          accept_c, hs_c, last_hs_c;
    logic [FW-1:0] src_data;
    logic [aw:0]   src_addr;

    logic          out_valid_nxt, out_last_nxt, busy_nxt, load_ready_nxt;
    logic [dw:0]   out_data_nxt;
    logic [aw:0]   out_addr_nxt;

    // Next-state and registered-output computation
    always_comb begin
        state_nxt      = state;
        full_nxt       = full;
        wr_nxt         = wr_ptr;
        rd_nxt         = rd_ptr;
        k_nxt          = k;
        fc_nxt         = frame_count;
        src_data       = buf_data[rd_ptr];
        src_addr       = buf_addr[rd_ptr];
        out_valid_nxt  = 1'b0;
        out_data_nxt   = '0;
        out_addr_nxt   = '0;
        out_last_nxt   = 1'b0;

        accept_c  = load_valid && load_ready;
        hs_c      = (state == DRAIN) && out_ready;
        last_hs_c = hs_c && (k == K_LAST);

        if (hs_c) begin
            k_nxt = last_hs_c ? '0 : k + KW'(1);
        end

        if (last_hs_c) begin
            full_nxt[rd_ptr] = 1'b0;
            rd_nxt           = ~rd_ptr;
            fc_nxt           = frame_count + 8'd1;
        end

        // load_ready guarantees wr_ptr names a buffer that is empty by this edge
        if (accept_c) begin
            full_nxt[wr_ptr] = 1'b1;
            wr_nxt           = ~wr_ptr;
        end

        case (state)
            IDLE:    if (accept_c) state_nxt = DRAIN;
            DRAIN:   if (last_hs_c && !full_nxt[rd_nxt]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // The frame being presented next may be the one captured on this edge
        if (accept_c && (wr_ptr == rd_nxt)) begin
            src_data = load_data;
            src_addr = base_addr;
        end else begin
            src_data = buf_data[rd_nxt];
            src_addr = buf_addr[rd_nxt];
        end

        out_valid_nxt = (state_nxt == DRAIN);
        if (out_valid_nxt) begin
            out_data_nxt = W'(src_data >> (W * 32'(k_nxt)));
            out_addr_nxt = src_addr + AW'(k_nxt);
            out_last_nxt = (k_nxt == K_LAST);
        end

        busy_nxt       = |full_nxt;
        load_ready_nxt = ~&full_nxt;
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= IDLE;
            full        <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            k           <= '0;
            frame_count <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_addr    <= '0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            load_ready  <= 1'b1;
        end else begin
            state       <= state_nxt;
            full        <= full_nxt;
            wr_ptr      <= wr_nxt;
            rd_ptr      <= rd_nxt;
            k           <= k_nxt;
            frame_count <= fc_nxt;
            out_valid   <= out_valid_nxt;
            out_data    <= out_data_nxt;
            out_addr    <= out_addr_nxt;
            out_last    <= out_last_nxt;
            busy        <= busy_nxt;
            load_ready  <= load_ready_nxt;
        end
    end

    // Frame storage; contents are meaningful only while the matching full bit is set
    always_ff @(posedge clk) begin
        if (accept_c) begin
            buf_data[wr_ptr] <= load_data;
            buf_addr[wr_ptr] <= base_addr;
        end
    end

endmodule
